z80_bus_bridge: RTL and testbench
=================================

Name: z80_bus_bridge

Overview:
- Sits directly downstream of the Z80 core inside the user project; consumes the core's bus-cycle strobes, address and data-out.
- Converts each Z80 memory or I/O cycle into one valid/ready request toward on-chip memory or peripherals.
- Stretches the cycle with wait_n until the target responds, and returns read data on the Z80 data-in bus.
- Same clock domain as the core; all Z80 strobes are sampled on the rising edge of wb_clk_i.

Parameters:
INT_VECTOR, 8'hFF, byte driven on din during an interrupt-acknowledge cycle (M1 and IORQ both low).
TIMEOUT, 255, cycles in REQ/RESP before a forced completion; used only with Z80BR_TIMEOUT_EN.

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous reset, active-high
m1_n  in  1  Z80 M1
mreq_n  in  1  Z80 MREQ
iorq_n  in  1  Z80 IORQ
rd_n  in  1  Z80 RD
wr_n  in  1  Z80 WR
rfsh_n  in  1  Z80 RFSH
addr  in  16  Z80 address
dout  in  8  Z80 data out (write data)
din  out  8  Z80 data in (read data / vector)
wait_n  out  1  Z80 WAIT
req_valid  out  1  downstream request valid
req_ready  in  1  downstream accepts request
req_we  out  1  1 = write
req_io  out  1  1 = I/O space, 0 = memory
req_addr  out  16  request address (I/O: full 16 bits, not truncated)
req_wdata  out  8  write data
rsp_valid  in  1  read data valid, one-cycle pulse
rsp_rdata  in  8  read data
timeout_o  out  1  sticky timeout flag (0 when Z80BR_TIMEOUT_EN is not defined)

Behaviour:
- Reset values (wb_rst_i high at a posedge): state IDLE, req_valid 0, req_we 0, req_io 0, req_addr 0, req_wdata 0, din 8'h00, wait_n 1, timeout_o 0.
- Reset mid-operation aborts the cycle immediately; the next posedge is IDLE with wait_n 1. An outstanding rsp_valid arriving later is ignored.

Cycle start: strobe = rfsh_n & ((~mreq_n | ~iorq_n) & (~rd_n | ~wr_n)).
- Refresh cycles (rfsh_n=0) never start a request.

States:
- IDLE: when strobe is sampled high at posedge N, the following are latched at posedge N:
  - req_addr <= addr
  - req_we <= ~wr_n
  - req_io <= ~iorq_n
  - req_wdata <= dout
  - wait_n <= 0, req_valid <= 1
  - Next state is REQ; wait_n is low from N+1.
- Interrupt acknowledge: if m1_n=0 and iorq_n=0 in IDLE (rd_n/wr_n not required):
  - din <= INT_VECTOR, no downstream request, wait_n stays 1.
  - Next state is DONE.
- REQ: req_valid held and all req_* fields stable until req_ready.
  - On req_ready with write: req_valid <= 0, wait_n <= 1, next state DONE.
  - On req_ready with read and rsp_valid in the same cycle: din <= rsp_rdata, wait_n <= 1, next state DONE.
  - On req_ready with read and no rsp_valid: req_valid <= 0, next state RESP.
- RESP: on rsp_valid, din <= rsp_rdata, wait_n <= 1, next state DONE. rsp_valid outside RESP/REQ is ignored.
- DONE: waits until (mreq_n & iorq_n) or (rd_n & wr_n), then goes to IDLE. This guarantees one request per Z80 cycle even though strobes span several clocks.
- Request-to-release latency: with req_ready and rsp_valid both held 1, wait_n is low for exactly 1 cycle.
- din holds its last value between cycles; it does not follow the bus.

Optional Feature:
Z80BR_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on entry to REQ and increments each cycle spent in REQ/RESP.
  - When it reaches TIMEOUT: req_valid <= 0, din <= 8'hFF (reads), wait_n <= 1, timeout_o <= 1 (sticky until reset), next state DONE.
- Not defined: no counter; REQ/RESP wait indefinitely; timeout_o is tied to 0.

Test Plan:
- Reset asserted in RESP with wait_n=0 -> next posedge: wait_n=1, req_valid=0, din=00. A subsequent stray rsp_valid leaves din=00.
- Memory read at addr 0x0001, req_ready=1, rsp_valid=1 the same cycle with rsp_rdata=3E -> one request with req_io=0, req_we=0, req_addr=0001; din=3E; wait_n low 1 cycle; exactly one req_valid beat across the whole multi-clock Z80 cycle.
- Memory write addr AA20, dout=1D, req_ready delayed 3 cycles -> req_valid held 4 cycles with req_addr=AA20, req_wdata=1D, req_we=1; wait_n low 4 cycles, then 1.
- I/O read port 0x1234, req_ready immediate, rsp_valid 5 cycles later with 5A -> req_io=1, req_addr=1234; state RESP for 5 cycles; din=5A.
- Interrupt acknowledge (m1_n=0, iorq_n=0, INT_VECTOR=CF), plus a refresh cycle with mreq_n=0, rd_n=0, rfsh_n=0 -> din=CF, no req_valid, wait_n stays 1; the refresh cycle produces no request.
- With Z80BR_TIMEOUT_EN defined and TIMEOUT=4, a read whose req_ready never asserts -> after 4 cycles: din=FF, timeout_o=1, wait_n=1. Without the macro: wait_n stays 0 and timeout_o stays 0.

Source files
------------

// File: rtl/z80_bus_bridge.sv
// Z80 bus-cycle to valid/ready bridge: one downstream request per Z80 memory/I/O cycle, WAIT stretching, read-data return.
// Optional forced completion of stalled cycles is enabled by defining Z80BR_TIMEOUT_EN.
module z80_bus_bridge #(
    parameter logic [7:0]  INT_VECTOR = 8'hFF,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    input  logic [15:0] addr,
    input  logic [7:0]  dout,
    output logic [7:0]  din,
    output logic        wait_n,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_we,
    output logic        req_io,
    output logic [15:0] req_addr,
    output logic [7:0]  req_wdata,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_rdata,
    output logic        timeout_o
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    localparam logic [8:0] TMO_LIM = 9'(TIMEOUT);

    state_t      state_q, state_d;
    logic        req_valid_q, req_valid_d;
    logic        req_we_q, req_we_d;
    logic        req_io_q, req_io_d;
    logic [15:0] req_addr_q, req_addr_d;
    logic [7:0]  req_wdata_q, req_wdata_d;
    logic [7:0]  din_q, din_d;
    logic        wait_n_q, wait_n_d;

    logic strobe, int_ack, bus_idle, tmo_fire;

    assign strobe   = rfsh_n & (~mreq_n | ~iorq_n) & (~rd_n | ~wr_n);
    assign int_ack  = ~m1_n & ~iorq_n;
    // The strobes span several clocks; DONE holds off until the Z80 ends the cycle.
    assign bus_idle = (mreq_n & iorq_n) | (rd_n & wr_n);

`ifdef Z80BR_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       timeout_q, timeout_d;
    logic       tmo_hit;

    assign tmo_hit  = ({1'b0, tmo_cnt_q} + 9'd1) == TMO_LIM;
    // A real response or handshake in the same cycle wins over the forced completion.
    assign tmo_fire = tmo_hit & (((state_q == S_REQ) & ~req_ready) |
                                 ((state_q == S_RESP) & ~rsp_valid));

    always_comb begin
        tmo_cnt_d = 8'd0;
        if (state_q == S_REQ || state_q == S_RESP)
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        timeout_d = timeout_q | tmo_fire;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tmo_cnt_q <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_tmo_lim;
    assign unused_tmo_lim = ^TMO_LIM;
    assign tmo_fire       = 1'b0;
    assign timeout_o      = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_io_q    <= 1'b0;
            req_addr_q  <= 16'h0000;
            req_wdata_q <= 8'h00;
            din_q       <= 8'h00;
            wait_n_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_we_q    <= req_we_d;
            req_io_q    <= req_io_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            din_q       <= din_d;
            wait_n_q    <= wait_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (int_ack)
                    state_d = S_DONE;
                else if (strobe)
                    state_d = S_REQ;
            end
            S_REQ: begin
                if (req_ready)
                    state_d = (req_we_q || rsp_valid) ? S_DONE : S_RESP;
                else if (tmo_fire)
                    state_d = S_DONE;
            end
            S_RESP: begin
                if (rsp_valid || tmo_fire)
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (bus_idle)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_valid_d = req_valid_q;
        req_we_d    = req_we_q;
        req_io_d    = req_io_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        din_d       = din_q;
        wait_n_d    = wait_n_q;
        case (state_q)
            S_IDLE: begin
                if (int_ack) begin
                    din_d = INT_VECTOR;
                end else if (strobe) begin
                    req_addr_d  = addr;
                    req_we_d    = ~wr_n;
                    req_io_d    = ~iorq_n;
                    req_wdata_d = dout;
                    req_valid_d = 1'b1;
                    wait_n_d    = 1'b0;
                end
            end
            S_REQ: begin
                if (req_ready) begin
                    req_valid_d = 1'b0;
                    if (req_we_q) begin
                        wait_n_d = 1'b1;
                    end else if (rsp_valid) begin
                        din_d    = rsp_rdata;
                        wait_n_d = 1'b1;
                    end
                end else if (tmo_fire) begin
                    req_valid_d = 1'b0;
                    wait_n_d    = 1'b1;
                    if (!req_we_q)
                        din_d = 8'hFF;
                end
            end
            S_RESP: begin
                if (rsp_valid) begin
                    din_d    = rsp_rdata;
                    wait_n_d = 1'b1;
                end else if (tmo_fire) begin
                    wait_n_d = 1'b1;
                    if (!req_we_q)
                        din_d = 8'hFF;
                end
            end
            default: ;
        endcase
    end

    assign req_valid = req_valid_q;
    assign req_we    = req_we_q;
    assign req_io    = req_io_q;
    assign req_addr  = req_addr_q;
    assign req_wdata = req_wdata_q;
    assign din       = din_q;
    assign wait_n    = wait_n_q;
endmodule

// File: tb/tb_z80_bus_bridge.sv
// Scoreboard bench for z80_bus_bridge: randomized Z80 cycles against a target model, with directed corner cases.
module tb_z80_bus_bridge;
`ifdef Z80BR_TIMEOUT_EN
    localparam int TMO   = 4;
    localparam int MAXD  = 1;
    localparam int MAXR  = 2;
    localparam int DIR_R = 2;
`else
    localparam int TMO   = 255;
    localparam int MAXD  = 3;
    localparam int MAXR  = 5;
    localparam int DIR_R = 5;
`endif
    localparam logic [7:0] VEC = 8'hCF;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  dout = 8'h00;
    logic [7:0]  din;
    logic        wait_n, req_valid, req_we, req_io, timeout_o;
    logic        req_ready = 1'b0, rsp_valid = 1'b0;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic [7:0]  rsp_rdata = 8'h00;

    always #5 wb_clk_i = ~wb_clk_i;

    z80_bus_bridge #(.INT_VECTOR(VEC), .TIMEOUT(TMO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
        .addr(addr), .dout(dout), .din(din), .wait_n(wait_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_io(req_io),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .timeout_o(timeout_o)
    );

    typedef struct packed {
        logic        we;
        logic        io;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } req_t;

    req_t       exp_q[$];
    int         dly_q[$];
    int         n_checks = 0, n_fail = 0, n_hs = 0, n_issued = 0;
    logic [7:0] exp_din = 8'h00;
    bit   [7:0] ref_mem[int];
    bit   [7:0] tgt_mem[int];

    function automatic logic [7:0] fill_val(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    function automatic logic [7:0] io_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h7C;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : fill_val(a);
    endfunction

    function automatic logic [7:0] tgt_rd(input logic [15:0] a);
        return tgt_mem.exists(int'(a)) ? tgt_mem[int'(a)] : fill_val(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake must match the oldest outstanding expected request.
    initial forever begin
        @(negedge wb_clk_i);
        #1;
        if (!wb_rst_i && req_valid === 1'b1 && req_ready === 1'b1) begin
            n_hs++;
            if (exp_q.size() == 0) begin
                check("unexpected_req", {8'h0, req_we, req_io, req_addr, 6'h0}, 32'h0);
            end else begin
                req_t e;
                e = exp_q.pop_front();
                check("req_we", req_we, e.we);
                check("req_io", req_io, e.io);
                check("req_addr", req_addr, e.addr);
                check("req_wdata", req_wdata, e.wdata);
            end
        end
    end

    // Target model: ready after d cycles (d<0: never), read data r cycles after the handshake.
    initial forever begin
        @(negedge wb_clk_i);
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        if (req_valid === 1'b1 && !wb_rst_i && dly_q.size() >= 2) begin
            int d, r;
            logic [7:0] val;
            d = dly_q.pop_front();
            r = dly_q.pop_front();
            val = 8'h00;
            if (d < 0) begin
                while (req_valid === 1'b1) @(negedge wb_clk_i);
            end else begin
                repeat (d) @(negedge wb_clk_i);
                req_ready = 1'b1;
                if (req_we) begin
                    if (!req_io) tgt_mem[int'(req_addr)] = req_wdata;
                end else begin
                    val = req_io ? io_val(req_addr) : tgt_rd(req_addr);
                end
                if (!req_we && r == 0) begin
                    rsp_valid = 1'b1;
                    rsp_rdata = val;
                end
                @(negedge wb_clk_i);
                req_ready = 1'b0;
                rsp_valid = 1'b0;
                if (!req_we && r > 0) begin
                    repeat (r - 1) @(negedge wb_clk_i);
                    rsp_valid = 1'b1;
                    rsp_rdata = val;
                    @(negedge wb_clk_i);
                    rsp_valid = 1'b0;
                end
            end
        end
    end

    // kind: 0 mem rd, 1 mem wr, 2 io rd, 3 io wr, 4 int ack, 5 refresh
    task automatic z80_cycle(input int kind, input logic [15:0] a, input logic [7:0] wd,
                             input int d, input int r);
        bit is_req, wr, io;
        int lows, exp_lows;
        is_req = (kind < 4);
        wr     = (kind == 1 || kind == 3);
        io     = (kind == 2 || kind == 3);
        lows   = 0;
        exp_lows = 0;
        if (is_req) begin
            if (d >= 0) begin
                exp_q.push_back('{wr, io, a, wd});
                n_issued++;
            end
            dly_q.push_back(d);
            dly_q.push_back(r);
            exp_lows = (d < 0) ? TMO : 1 + d + (wr ? 0 : r);
            if (!wr) exp_din = (d < 0) ? 8'hFF : (io ? io_val(a) : ref_rd(a));
            if (wr && !io) ref_mem[int'(a)] = wd;
        end else if (kind == 4) begin
            exp_din = VEC;
        end
        @(negedge wb_clk_i);
        addr   = a;
        dout   = wd;
        m1_n   = (kind != 4);
        mreq_n = !(kind == 0 || kind == 1 || kind == 5);
        iorq_n = !(kind == 2 || kind == 3 || kind == 4);
        rd_n   = !(kind == 0 || kind == 2 || kind == 5);
        wr_n   = !wr;
        rfsh_n = (kind != 5);
        @(negedge wb_clk_i);
        while (wait_n === 1'b0 && lows < 400) begin
            lows++;
            @(negedge wb_clk_i);
        end
        check("wait_low_cycles", lows, exp_lows);
        @(negedge wb_clk_i);
        {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} = 6'b111111;
        repeat (2) @(negedge wb_clk_i);
        check("din", din, exp_din);
        check("wait_n_idle", wait_n, 1);
        $display("txn kind=%0d addr=%04h wdata=%02h d=%0d r=%0d wait_low=%0d din=%02h", kind, a, wd, d, r, lows, din);
    endtask

    initial begin
        repeat (3) @(negedge wb_clk_i);
        check("rst_wait_n", wait_n, 1);
        check("rst_req_valid", req_valid, 0);
        check("rst_din", din, 0);
        check("rst_req_addr", req_addr, 0);
        check("rst_timeout", timeout_o, 0);
        wb_rst_i = 1'b0;

        ref_mem[1] = 8'h3E;
        tgt_mem[1] = 8'h3E;
        z80_cycle(0, 16'h0001, 8'h00, 0, 0);
        z80_cycle(1, 16'hAA20, 8'h1D, 3, 0);
        z80_cycle(2, 16'h1234, 8'h00, 0, DIR_R);
        z80_cycle(4, 16'h0038, 8'h00, 0, 0);
        z80_cycle(5, 16'h0002, 8'h00, 0, 0);

        for (int i = 0; i < 60; i++) begin
            int k;
            logic [15:0] a;
            k = $urandom_range(0, 5);
            a = (k < 2) ? 16'($urandom_range(0, 31)) : 16'($urandom);
            z80_cycle(k, a, 8'($urandom), $urandom_range(0, MAXD), $urandom_range(0, MAXR));
        end

        // Reset in the middle of a read waiting in RESP; the late response must be ignored.
        tgt_mem[16'h40] = 8'h77;
        exp_q.push_back('{1'b0, 1'b0, 16'h0040, 8'h00});
        n_issued++;
        dly_q.push_back(0);
        dly_q.push_back(30);
        @(negedge wb_clk_i);
        addr = 16'h0040; dout = 8'h00; mreq_n = 1'b0; rd_n = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        check("pre_reset_wait_n", wait_n, 0);
        wb_rst_i = 1'b1;
        {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} = 6'b111111;
        @(negedge wb_clk_i);
        check("midrst_wait_n", wait_n, 1);
        check("midrst_req_valid", req_valid, 0);
        check("midrst_din", din, 0);
        check("midrst_req_wdata", req_wdata, 0);
        wb_rst_i = 1'b0;
        repeat (40) @(negedge wb_clk_i);
        check("stray_rsp_din", din, 0);
        exp_din = 8'h00;

`ifdef Z80BR_TIMEOUT_EN
        z80_cycle(0, 16'h0005, 8'h00, -1, 0);
        check("timeout_flag", timeout_o, 1);
`else
        z80_cycle(0, 16'h0005, 8'h00, 20, 0);
        check("timeout_flag", timeout_o, 0);
`endif

        repeat (5) @(negedge wb_clk_i);
        check("scoreboard_empty", exp_q.size(), 0);
        check("handshake_count", n_hs, n_issued);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end
endmodule
